control_logic: RTL and testbench

Synchronous interrupt-control core of the 8259A-compatible PIC, directly downstream of the read/write decode stage. It consumes the decoded command code (`WR_cur`), the strobe flags and the data bus byte, and holds the IMR, IRR, ISR and vector base. It resolves fixed priority, raises `INT`, and runs the two-pulse `INTA` sequence in 8086 mode. It also drives status reads and the interrupt vector back onto the data bus.

---
 rtl/control_logic.sv | 213 +++++++++++++++++++++
 tb/tb_control_logic.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_logic.sv
// Interrupt-control core of an 8259A-compatible PIC: holds IMR/IRR/ISR and the vector
// base, resolves fixed priority, drives INT and runs the two-pulse 8086 INTA sequence.
module control_logic (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] WR_cur,
    input  logic       WR_flag,
    input  logic       RD_flag,
    input  logic       A0,
    input  logic [7:0] Ds,
    input  logic [7:0] IR,
    input  logic       INTA_n,
    output logic       INT,
    output logic [7:0] D_out,
    output logic       D_oe,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK1 = 2'b01,
        ACK2 = 2'b10
    } state_t;

    localparam logic [2:0] CMD_ICW1 = 3'b000;
    localparam logic [2:0] CMD_ICW2 = 3'b001;
    localparam logic [2:0] CMD_ICW3 = 3'b010;
    localparam logic [2:0] CMD_ICW4 = 3'b011;
    localparam logic [2:0] CMD_OCW1 = 3'b100;
    localparam logic [2:0] CMD_OCW2 = 3'b101;
    localparam logic [2:0] CMD_OCW3 = 3'b110;

    state_t     state, state_d;
    logic       wr_prev, inta_prev;
    logic [7:0] ir_prev;
    logic [7:0] imr, imr_d, irr, irr_d, isr, isr_d;
    logic [4:0] t_base, t_base_d;
    logic       ltim, ltim_d, aeoi, aeoi_d, sngl, sngl_d, ic4, ic4_d;
    logic       read_sel, read_sel_d, init_done, init_done_d;
    logic [2:0] lvl, lvl_d;
    logic       spurious, spurious_d;
    logic       int_d, doe_d;
    logic [7:0] dout_d;

    logic       wr_commit, inta_fall, inta_rise, icw1_commit;
    logic [7:0] pending, ack_set, aeoi_clr, eoi_clr;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    // Strobes are level flags from the decode stage; a write takes effect once,
    // on the first cycle WR_flag is seen high, and INTA_n edges step the FSM.
    assign wr_commit   = WR_flag & ~wr_prev;
    assign icw1_commit = wr_commit && (WR_cur == CMD_ICW1);
    assign inta_fall   = ~INTA_n & inta_prev;
    assign inta_rise   = INTA_n & ~inta_prev;
    assign pending     = irr & ~imr;
    assign fsm_state   = state;

    always_comb begin
        state_d    = state;
        lvl_d      = lvl;
        spurious_d = spurious;
        ack_set    = '0;
        aeoi_clr   = '0;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    if (pending != 8'h00) begin
                        lvl_d      = lowest_idx(pending);
                        spurious_d = 1'b0;
                        ack_set    = 8'd1 << lowest_idx(pending);
                    end else begin
                        lvl_d      = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_fall) state_d = ACK2;
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
                    if (aeoi && !spurious) aeoi_clr = 8'd1 << lvl;
                end
            end
            default: state_d = IDLE;
        endcase
        if (icw1_commit) state_d = IDLE;
    end

    always_comb begin
        eoi_clr = '0;
        if (wr_commit && (WR_cur == CMD_OCW2)) begin
            case (Ds[7:5])
                3'b001:  if (isr != 8'h00) eoi_clr = 8'd1 << lowest_idx(isr);
                3'b011:  eoi_clr = 8'd1 << Ds[2:0];
                default: eoi_clr = '0;
            endcase
        end
    end

    // EOI clears are applied before the acknowledge sets the new ISR bit.
    always_comb begin
        imr_d       = imr;
        t_base_d    = t_base;
        ltim_d      = ltim;
        aeoi_d      = aeoi;
        sngl_d      = sngl;
        ic4_d       = ic4;
        read_sel_d  = read_sel;
        init_done_d = init_done;
        irr_d       = ltim ? IR : ((irr & ~ack_set) | (IR & ~ir_prev));
        isr_d       = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        if (wr_commit) begin
            case (WR_cur)
                CMD_ICW1: begin
                    ltim_d      = Ds[3];
                    sngl_d      = Ds[1];
                    ic4_d       = Ds[0];
                    imr_d       = '0;
                    irr_d       = '0;
                    isr_d       = '0;
                    read_sel_d  = 1'b0;
                    init_done_d = 1'b0;
                end
                CMD_ICW2: begin
                    t_base_d = Ds[7:3];
                    if (!init_done) init_done_d = sngl & ~ic4;
                end
                CMD_ICW3: begin
                    if (!init_done) init_done_d = ~ic4;
                end
                CMD_ICW4: begin
                    aeoi_d      = Ds[1];
                    init_done_d = 1'b1;
                end
                CMD_OCW1: imr_d = Ds;
                CMD_OCW3: if (Ds[1]) read_sel_d = Ds[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        dout_d = D_out;
        doe_d  = 1'b0;
        if (state == ACK1 && inta_fall) begin
            dout_d = {t_base, lvl};
            doe_d  = 1'b1;
        end else if (state == ACK2) begin
            doe_d = inta_rise ? 1'b0 : D_oe;
        end else if (state == IDLE && RD_flag) begin
            doe_d  = 1'b1;
            dout_d = A0 ? imr : (read_sel ? isr : irr);
        end
        if (icw1_commit) doe_d = 1'b0;
    end

    assign int_d = init_done && (pending != 8'h00) &&
                   ((isr == 8'h00) || (lowest_idx(pending) < lowest_idx(isr)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wr_prev   <= 1'b0;
            inta_prev <= 1'b1;
            ir_prev   <= '0;
            imr       <= 8'hFF;
            irr       <= '0;
            isr       <= '0;
            t_base    <= '0;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
            read_sel  <= 1'b0;
            init_done <= 1'b0;
            lvl       <= 3'd0;
            spurious  <= 1'b0;
            INT       <= 1'b0;
            D_out     <= '0;
            D_oe      <= 1'b0;
        end else begin
            state     <= state_d;
            wr_prev   <= WR_flag;
            inta_prev <= INTA_n;
            ir_prev   <= IR;
            imr       <= imr_d;
            irr       <= irr_d;
            isr       <= isr_d;
            t_base    <= t_base_d;
            ltim      <= ltim_d;
            aeoi      <= aeoi_d;
            sngl      <= sngl_d;
            ic4       <= ic4_d;
            read_sel  <= read_sel_d;
            init_done <= init_done_d;
            lvl       <= lvl_d;
            spurious  <= spurious_d;
            INT       <= int_d;
            D_out     <= dout_d;
            D_oe      <= doe_d;
        end
    end

endmodule

// File: tb/tb_control_logic.sv
// Bench for control_logic: directed vector table, hand-written multi-cycle corners,
// and randomized traffic checked against a transaction-level model.
module tb_control_logic;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] WR_cur;
    logic       WR_flag, RD_flag, A0, INTA_n;
    logic [7:0] Ds, IR;
    logic       INT, D_oe;
    logic [7:0] D_out;
    logic [1:0] fsm_state;

    control_logic dut (
        .CLK(CLK), .RST(RST), .WR_cur(WR_cur), .WR_flag(WR_flag), .RD_flag(RD_flag),
        .A0(A0), .Ds(Ds), .IR(IR), .INTA_n(INTA_n), .INT(INT), .D_out(D_out),
        .D_oe(D_oe), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] code, input logic [7:0] data);
        WR_cur = code; Ds = data; WR_flag = 1'b1;
        tick;
        WR_flag = 1'b0;
        tick;
    endtask

    task automatic rd(input logic a0, output logic [7:0] data);
        A0 = a0; RD_flag = 1'b1;
        tick;
        data = D_out;
        check("rd_oe", {7'b0, D_oe}, 8'h01);
        RD_flag = 1'b0;
        tick;
        check("rd_oe_drop", {7'b0, D_oe}, 8'h00);
    endtask

    task automatic set_ir(input logic [7:0] v);
        IR = v;
        tick;
        tick;
    endtask

    task automatic inta_seq(output logic [7:0] vec);
        INTA_n = 1'b0; tick;
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick;
        vec = D_out;
        check("vec_oe", {7'b0, D_oe}, 8'h01);
        INTA_n = 1'b1; tick;
        check("vec_oe_drop", {7'b0, D_oe}, 8'h00);
        tick;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] m_imr = 8'hFF, m_irr = 8'h00, m_isr = 8'h00, m_ir = 8'h00;
    logic [4:0] m_t = 5'd0;
    logic       m_ltim = 0, m_aeoi = 0, m_sngl = 0, m_ic4 = 0, m_rsel = 0, m_init = 0;

    function automatic logic [7:0] low_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic m_int();
        logic [7:0] p;
        p = m_irr & ~m_imr;
        return m_init && (p != 8'h00) && ((m_isr == 8'h00) || (low_bit(p) < low_bit(m_isr)));
    endfunction

    task automatic m_write(input logic [2:0] code, input logic [7:0] data);
        case (code)
            3'd0: begin
                m_ltim = data[3]; m_sngl = data[1]; m_ic4 = data[0];
                m_imr = 0; m_irr = 0; m_isr = 0; m_rsel = 0; m_init = 0;
            end
            3'd1: begin
                m_t = data[7:3];
                if (!m_init && m_sngl && !m_ic4) m_init = 1;
            end
            3'd2: if (!m_init && !m_ic4) m_init = 1;
            3'd3: begin m_aeoi = data[1]; m_init = 1; end
            3'd4: m_imr = data;
            3'd5: begin
                if (data[7:5] == 3'b001) m_isr = m_isr & ~low_bit(m_isr);
                else if (data[7:5] == 3'b011) m_isr = m_isr & ~(8'd1 << data[2:0]);
            end
            3'd6: if (data[1]) m_rsel = data[0];
            default: ;
        endcase
        if (m_ltim) m_irr = m_ir;
    endtask

    task automatic m_ack(output logic [7:0] vec);
        logic [7:0] p, b;
        p = m_irr & ~m_imr;
        if (p != 8'h00) begin
            b = low_bit(p);
            m_isr = m_isr | b;
            m_irr = m_irr & ~b;
            vec = {m_t, 3'($clog2(b))};
            if (m_aeoi) m_isr = m_isr & ~b;
        end else begin
            vec = {m_t, 3'd7};
        end
        if (m_ltim) m_irr = m_ir;
    endtask

    task automatic wr_m(input logic [2:0] code, input logic [7:0] data);
        wr(code, data);
        m_write(code, data);
    endtask

    task automatic run_random(input logic level, input logic aeoi_on, input int iters);
        logic [7:0] got, exp, v;
        logic [4:0] tt;
        logic       sel, a0;
        IR = 8'h00; m_ir = 8'h00;
        tick;
        tt = 5'($urandom_range(0, 31));
        wr_m(3'd0, level ? 8'h1B : 8'h13);
        wr_m(3'd1, {tt, 3'b000});
        wr_m(3'd3, aeoi_on ? 8'h03 : 8'h01);
        check("rand_init_int", {7'b0, INT}, {7'b0, m_int()});
        for (int k = 0; k < iters; k++) begin
            case ($urandom_range(0, 4))
                0: begin
                    v = 8'($urandom);
                    set_ir(v);
                    if (level) m_irr = v;
                    else m_irr = m_irr | (v & ~m_ir);
                    m_ir = v;
                end
                1: wr_m(3'd4, 8'($urandom & $urandom));
                2: begin
                    inta_seq(got);
                    m_ack(exp);
                    check("rand_vec", got, exp);
                end
                3: begin
                    if ($urandom_range(0, 1) == 1) wr_m(3'd5, 8'h20);
                    else wr_m(3'd5, {5'b01100, 3'($urandom_range(0, 7))});
                end
                default: begin
                    sel = 1'($urandom_range(0, 1));
                    a0  = 1'($urandom_range(0, 1));
                    wr_m(3'd6, {7'b0000101, sel});
                    rd(a0, got);
                    exp = a0 ? m_imr : (m_rsel ? m_isr : m_irr);
                    check("rand_rd", got, exp);
                end
            endcase
            check("rand_int", {7'b0, INT}, {7'b0, m_int()});
        end
    endtask

    // ---------------- directed vector table ----------------
    localparam logic [2:0] OP_WR = 3'd0, OP_IR = 3'd1, OP_RD = 3'd2, OP_INTA = 3'd3, OP_INT = 3'd4;

    typedef struct {
        logic [2:0] op;
        logic [2:0] code;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] op, input logic [2:0] code, input logic [7:0] data,
                       input logic [7:0] exp);
        vec_t e;
        e.op = op; e.code = code; e.data = data; e.exp = exp;
        tbl.push_back(e);
    endtask

    initial begin
        logic [7:0] got;

        RST = 1'b1; WR_cur = 3'd0; WR_flag = 1'b0; RD_flag = 1'b0; A0 = 1'b0;
        Ds = 8'h00; IR = 8'h00; INTA_n = 1'b1;
        tick; tick;
        check("rst_int", {7'b0, INT}, 8'h00);
        check("rst_dout", D_out, 8'h00);
        check("rst_doe", {7'b0, D_oe}, 8'h00);
        check("rst_fsm", {6'b0, fsm_state}, 8'h00);
        RST = 1'b0;
        tick;
        rd(1'b1, got); check("rst_imr", got, 8'hFF);
        rd(1'b0, got); check("rst_irr", got, 8'h00);

        // init then request (edge, single, IC4, AEOI)
        add(OP_WR, 3'd0, 8'h13, 0); add(OP_WR, 3'd1, 8'h40, 0); add(OP_WR, 3'd3, 8'h03, 0);
        add(OP_IR, 0, 8'h08, 8'h01); add(OP_INTA, 0, 0, 8'h43); add(OP_INT, 0, 0, 8'h00);
        add(OP_WR, 3'd6, 8'h0B, 0); add(OP_RD, 3'd0, 0, 8'h00);
        // priority and nesting, AEOI off
        add(OP_WR, 3'd0, 8'h13, 0); add(OP_WR, 3'd1, 8'h40, 0); add(OP_WR, 3'd3, 8'h01, 0);
        add(OP_IR, 0, 8'h00, 8'h00); add(OP_IR, 0, 8'h20, 8'h01); add(OP_INTA, 0, 0, 8'h45);
        add(OP_INT, 0, 0, 8'h00); add(OP_WR, 3'd6, 8'h0B, 0); add(OP_RD, 3'd0, 0, 8'h20);
        add(OP_IR, 0, 8'h64, 8'h01); add(OP_INTA, 0, 0, 8'h42); add(OP_RD, 3'd0, 0, 8'h24);
        add(OP_INT, 0, 0, 8'h00); add(OP_WR, 3'd5, 8'h20, 0); add(OP_RD, 3'd0, 0, 8'h20);
        add(OP_INT, 0, 0, 8'h00); add(OP_WR, 3'd5, 8'h65, 0); add(OP_INT, 0, 0, 8'h01);
        add(OP_RD, 3'd0, 0, 8'h00); add(OP_INTA, 0, 0, 8'h46); add(OP_WR, 3'd5, 8'h20, 0);
        add(OP_IR, 0, 8'h00, 8'h00);
        // mask
        add(OP_WR, 3'd4, 8'h08, 0); add(OP_IR, 0, 8'h08, 8'h00); add(OP_WR, 3'd6, 8'h0A, 0);
        add(OP_RD, 3'd0, 0, 8'h08); add(OP_RD, 3'd1, 0, 8'h08); add(OP_WR, 3'd4, 8'h00, 0);
        add(OP_INT, 0, 0, 8'h01); add(OP_INTA, 0, 0, 8'h43); add(OP_WR, 3'd5, 8'h20, 0);
        add(OP_IR, 0, 8'h00, 8'h00);
        // spurious in level mode
        add(OP_WR, 3'd0, 8'h1B, 0); add(OP_WR, 3'd1, 8'h40, 0); add(OP_WR, 3'd3, 8'h01, 0);
        add(OP_IR, 0, 8'h08, 8'h01); add(OP_IR, 0, 8'h00, 8'h00); add(OP_INTA, 0, 0, 8'h47);
        add(OP_WR, 3'd6, 8'h0B, 0); add(OP_RD, 3'd0, 0, 8'h00);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR: wr(tbl[i].code, tbl[i].data);
                OP_IR: begin
                    set_ir(tbl[i].data);
                    check($sformatf("tbl%0d_int", i), {7'b0, INT}, tbl[i].exp);
                end
                OP_RD: begin
                    rd(tbl[i].code[0], got);
                    check($sformatf("tbl%0d_rd", i), got, tbl[i].exp);
                end
                OP_INTA: begin
                    inta_seq(got);
                    check($sformatf("tbl%0d_vec", i), got, tbl[i].exp);
                end
                default: check($sformatf("tbl%0d_int", i), {7'b0, INT}, tbl[i].exp);
            endcase
        end

        // INT latency, then reset while in ACK2
        wr(3'd0, 8'h13); wr(3'd1, 8'h40); wr(3'd3, 8'h01);
        IR = 8'h02;
        tick; check("lat_int_early", {7'b0, INT}, 8'h00);
        tick; check("lat_int", {7'b0, INT}, 8'h01);
        INTA_n = 1'b0; tick; check("ack1_fsm", {6'b0, fsm_state}, 8'h01);
        INTA_n = 1'b1; tick;
        INTA_n = 1'b0; tick;
        check("ack2_fsm", {6'b0, fsm_state}, 8'h02);
        check("ack2_oe", {7'b0, D_oe}, 8'h01);
        check("ack2_vec", D_out, 8'h41);
        RST = 1'b1; tick;
        check("rst_ack_oe", {7'b0, D_oe}, 8'h00);
        check("rst_ack_fsm", {6'b0, fsm_state}, 8'h00);
        check("rst_ack_int", {7'b0, INT}, 8'h00);
        RST = 1'b0; INTA_n = 1'b1; IR = 8'h00;
        tick;
        rd(1'b1, got); check("rst_ack_imr", got, 8'hFF);
        rd(1'b0, got); check("rst_ack_irr", got, 8'h00);

        run_random(1'b0, 1'b0, 150);
        run_random(1'b0, 1'b1, 100);
        run_random(1'b1, 1'b0, 120);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
